// File: rtl/video_pkg.sv
// video_pkg: shared colour/timing types and standard raster constants for scanout
package video_pkg;

  typedef logic [11:0] rgb_444_t;

  typedef struct packed {
    int unsigned w;
    int unsigned h;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  typedef struct packed {
    logic [1:0] blank;
    logic [1:0] sync;
    logic       en;
    logic       strb;
    logic       fs;
    logic       vb;
  } stage_t;

  localparam timing_t VGA_640X480 = '{w: 640, h: 480, h_fp: 16, h_sync: 96, h_bp: 48,
                                      v_fp: 10, v_sync: 2, v_bp: 33};

  localparam logic [1:0] SYNC_ACTIVE_HIGH = 2'b00;
  localparam logic [1:0] SYNC_ACTIVE_LOW  = 2'b11;

  function automatic int unsigned full_w(timing_t t);
    return t.w + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned full_h(timing_t t);
    return t.h + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/video_raster_counter.sv
// video_raster_counter: x/y raster position with blank, sync and event decode
module video_raster_counter
  import video_pkg::*;
#(
  parameter timing_t    T        = VGA_640X480,
  parameter logic [1:0] SYNC_POL = SYNC_ACTIVE_HIGH
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [1:0] blank,
  output logic [1:0] sync,
  output logic       active,
  output logic       line_end,
  output logic       frame_pt,
  output logic       vblank_pt,
  output logic       wrap
);

  localparam int unsigned WF = full_w(T);
  localparam int unsigned HF = full_h(T);
  localparam int XW = $clog2(WF);
  localparam int YW = $clog2(HF);
  localparam logic [XW-1:0] X_LAST  = XW'(WF - 1);
  localparam logic [XW-1:0] X_AEND  = XW'(T.w - 1);
  localparam logic [XW-1:0] X_ACT   = XW'(T.w);
  localparam logic [XW-1:0] HS_ON   = XW'(T.w + T.h_fp);
  localparam logic [XW-1:0] HS_OFF  = XW'(T.w + T.h_fp + T.h_sync);
  localparam logic [YW-1:0] Y_LAST  = YW'(HF - 1);
  localparam logic [YW-1:0] Y_ACT   = YW'(T.h);
  localparam logic [YW-1:0] VS_ON   = YW'(T.h + T.v_fp);
  localparam logic [YW-1:0] VS_OFF  = YW'(T.h + T.v_fp + T.v_sync);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic hb, vb, hs, vs;

  // Free-running raster position; y advances when x wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x == X_LAST ? '0 : x + XW'(1);
      if (x == X_LAST) y <= y == Y_LAST ? '0 : y + YW'(1);
    end
  end

  // Blank/sync windows and per-position events decoded from the current raster
  always_comb begin
    hb        = x >= X_ACT;
    vb        = y >= Y_ACT;
    hs        = x >= HS_ON && x < HS_OFF;
    vs        = y >= VS_ON && y < VS_OFF;
    blank     = {vb, hb};
    sync      = {vs, hs} ^ SYNC_POL;
    active    = !hb && !vb;
    line_end  = x == X_AEND && !vb;
    frame_pt  = x == '0 && y == '0;
    vblank_pt = x == '0 && y == Y_ACT;
    wrap      = x == X_LAST && y == Y_LAST;
  end

endmodule

// File: rtl/video_scanout.sv
// video_scanout: scaled framebuffer fetch plus latency-compensated VGA output pipeline
module video_scanout
  import video_pkg::*;
#(
  parameter int         W            = 640,
  parameter int         H            = 480,
  parameter int         H_FP         = 16,
  parameter int         H_SYNC       = 96,
  parameter int         H_BP         = 48,
  parameter int         V_FP         = 10,
  parameter int         V_SYNC       = 2,
  parameter int         V_BP         = 33,
  parameter int         SCALE_X      = 4,
  parameter int         SCALE_Y      = 4,
  parameter int         COLOR_BITS   = 12,
  parameter int         READ_LATENCY = 1,
  parameter logic [1:0] SYNC_POL     = 2'b00,
  localparam int        ADDR_BITS    = $clog2((W / SCALE_X) * (H / SCALE_Y))
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [COLOR_BITS-1:0] border,
  output logic [ADDR_BITS-1:0]  fetch_addr,
  output logic                  fetch_strobe,
  input  logic [COLOR_BITS-1:0] fetch_data,
  output logic [COLOR_BITS-1:0] pixel,
  output logic [1:0]            blank,
  output logic [1:0]            sync,
  output logic                  frame_start,
  output logic                  vblank_start,
  output logic [7:0]            frame_count
);

  localparam timing_t T = '{w: W, h: H, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
                            v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP};
  localparam int D   = READ_LATENCY + 1;
  localparam int SXW = SCALE_X > 1 ? $clog2(SCALE_X) : 1;
  localparam int SYW = SCALE_Y > 1 ? $clog2(SCALE_Y) : 1;
  localparam logic [SXW-1:0]       SX_LAST  = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0]       SY_LAST  = SYW'(SCALE_Y - 1);
  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(W / SCALE_X);
  localparam stage_t IDLE = '{blank: 2'b11, sync: SYNC_POL, en: 1'b0, strb: 1'b0,
                              fs: 1'b0, vb: 1'b0};

  if (W % SCALE_X != 0) begin : g_bad_sx
    $error("W must be a multiple of SCALE_X");
  end
  if (H % SCALE_Y != 0) begin : g_bad_sy
    $error("H must be a multiple of SCALE_Y");
  end
  if (READ_LATENCY < 1) begin : g_bad_rl
    $error("READ_LATENCY must be at least 1");
  end

  logic [1:0]            blank_r, sync_r;
  logic                  active, line_end, frame_pt, vblank_pt, wrap;
  logic [SXW-1:0]        sx;
  logic [SYW-1:0]        sy;
  logic [ADDR_BITS-1:0]  col, row_base;
  logic                  en_lat, en_frame;
  logic [COLOR_BITS-1:0] held;
  stage_t                cur;
  stage_t                pipe [D];

  video_raster_counter #(.T(T), .SYNC_POL(SYNC_POL)) u_raster (
    .clock     (clock),
    .reset_n   (reset_n),
    .blank     (blank_r),
    .sync      (sync_r),
    .active    (active),
    .line_end  (line_end),
    .frame_pt  (frame_pt),
    .vblank_pt (vblank_pt),
    .wrap      (wrap)
  );

  assign fetch_strobe = pipe[0].strb;

  // At (0,0) the live enable governs so the first frame after reset can fetch
  always_comb begin
    en_frame = frame_pt ? enable : en_lat;
    cur      = '{blank: blank_r, sync: sync_r, en: en_frame,
                 strb: active && sx == '0 && en_frame, fs: frame_pt, vb: vblank_pt};
  end

  // Incremental source walk: sx/col across a line, sy/row_base down the frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sx          <= '0;
      sy          <= '0;
      col         <= '0;
      row_base    <= '0;
      en_lat      <= 1'b0;
      frame_count <= '0;
    end else begin
      if (frame_pt) en_lat <= enable;
      if (active) begin
        sx  <= sx == SX_LAST ? '0 : sx + SXW'(1);
        col <= line_end ? '0 : (sx == SX_LAST ? col + ADDR_BITS'(1) : col);
      end
      if (line_end) begin
        sy <= sy == SY_LAST ? '0 : sy + SYW'(1);
        if (sy == SY_LAST) row_base <= row_base + ROW_STEP;
      end
      if (wrap) begin
        sy          <= '0;
        row_base    <= '0;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Fetch request register and the delay line matching the memory read latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr <= '0;
      for (int i = 0; i < D; i++) pipe[i] <= IDLE;
    end else begin
      fetch_addr <= row_base + col;
      pipe[0]    <= cur;
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Output stage: capture returning data, hold it across the scaled pixels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held         <= '0;
      pixel        <= '0;
      blank        <= 2'b11;
      sync         <= SYNC_POL;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      if (pipe[READ_LATENCY].strb) held <= fetch_data;
      pixel        <= pipe[READ_LATENCY].blank != 2'b00 ? '0 :
                      !pipe[READ_LATENCY].en ? border :
                      pipe[READ_LATENCY].strb ? fetch_data : held;
      blank        <= pipe[READ_LATENCY].blank;
      sync         <= pipe[READ_LATENCY].sync;
      frame_start  <= pipe[READ_LATENCY].fs;
      vblank_start <= pipe[READ_LATENCY].vb;
    end
  end

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
Next-generation framebuffer scanout engine: raster timing, scaled framebuffer address generation and a latency-compensated output pipeline in a single pixel-clock domain.
- Independent horizontal/vertical scale factors, programmable sync polarity, border colour and configurable memory read latency.
- Sits between the dual-port frame BRAM read port and the VGA pins.
- Adds frame-start and vblank events for the CPU-side interrupt logic.

Parameters:
W, 640, active width in pixels
H, 480, active height in lines
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width
SCALE_X, 4, output pixels per source pixel horizontally (>=1)
SCALE_Y, 4, output lines per source line vertically (>=1)
COLOR_BITS, 12, pixel width (RGB 4:4:4)
READ_LATENCY, 1, cycles from fetch_strobe to valid fetch_data (>=1)
SYNC_POL, 2'b00, per-axis sync polarity, bit0 = H, bit1 = V; 0 = active-high
ADDR_BITS, $clog2(W/SCALE_X*H/SCALE_Y), localparam, fetch address width

Ports:
clock  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  scanout enable; sampled at frame start only
border  in  COLOR_BITS  colour driven in the active area while disabled
fetch_addr  out  ADDR_BITS  framebuffer word address
fetch_strobe  out  1  read request for fetch_addr
fetch_data  in  COLOR_BITS  read data, valid READ_LATENCY cycles after strobe
pixel  out  COLOR_BITS  output colour, 0 when blanked
blank  out  2  {V, H} blanking
sync  out  2  {V, H} sync, polarity per SYNC_POL
frame_start  out  1  one-cycle pulse aligned with first active pixel of a frame
vblank_start  out  1  one-cycle pulse aligned with first pixel of line H
frame_count  out  8  frames completed, wraps 255->0

Behaviour:
- Reset (async assert, sync release) sets x=y=0 and clears sub-counters, row base and address.
- Outputs during reset: pixel=0, blank=2'b11, sync inactive (= SYNC_POL), fetch_strobe=0, pulses 0, frame_count=0, latched enable=0.
- Raster counters:
  - x counts 0..W_FULL-1; on wrap, y increments.
  - y counts 0..H_FULL-1 and wraps to 0.
  - blank/sync decode is identical to the existing timing: H sync on x in [W+H_FP, W+H_FP+H_SYNC).
- Address generation: incremental only; no divider or multiplier on the address path.
  - sx counts 0..SCALE_X-1 across active x and resets at x=0.
  - Within an active line, fetch_addr = row_base + source column. The column increments when sx wraps.
  - sy counts 0..SCALE_Y-1 per active line.
  - At the end of active line y (x=W-1) with sy=SCALE_Y-1, row_base += W/SCALE_X.
  - At y wrap, row_base=0 and sy=0.
- fetch_strobe=1 exactly on active cycles with sx==0 and latched enable=1; 0 in blanking.
  - fetch_addr is don't-care while strobe=0.
- Data hold: fetch_data is captured READ_LATENCY cycles after each strobe and held for SCALE_X output pixels.
- Pipeline:
  - blank, sync, enable-qualifier and event pulses are delayed D = READ_LATENCY+1 cycles.
  - All outputs are registered.
  - pixel = blank_d!=0 ? 0 : (en_d ? held_data : border).
- Enable: latched at x=0,y=0 and used for the whole frame. Mid-frame changes have no effect until the next frame.
- Events:
  - frame_start asserts at raster (0,0) delayed by D.
  - vblank_start asserts at (0,H) delayed by D.
  - frame_count increments on the y wrap.
- Reset mid-frame restarts at (0,0). The pipeline is flushed, so no stale pixel or pulse appears after release.
- Elaboration errors: W%SCALE_X!=0, H%SCALE_Y!=0, READ_LATENCY<1.

Decomposition:
- Shared video_pkg:
  - RGB_444 typedef
  - timing-parameter struct
  - standard 640x480@60 constants
  - sync-polarity constants
- One sub-module, video_raster_counter: x/y counters plus blank/sync/event decode. It replaces the old timing counter and adds reset_n and polarity.

Test Plan:
- Reset, W=8 H=4 porches 1/1/1, SCALE 2/2, READ_LATENCY=1 -> while reset_n=0: pixel=0, blank=11, sync=00, fetch_strobe=0; after release first strobe at x=0 with addr 0.
- Same config, enable=1 -> strobes at x=0,2,4,6 with addr 0,1,2,3 on lines 0 and 1, addr 4..7 on lines 2 and 3; addr 0 again next frame.
- READ_LATENCY=3, fetch_data = addr+0x100 -> pixel columns 0..7 of line 0 read 0x100,0x100,0x101,0x101,…; blank and sync edges coincide with pixel edges (D=4).
- SYNC_POL=2'b11, 640x480 default -> sync[0] low for exactly 96 cycles per line; sync[1] low for 2 lines; frame_count increments once per 420000 cycles.
- enable dropped mid-frame, border=0xF00 -> current frame unchanged; next frame active area all 0xF00 with no strobes.
- reset_n pulsed at y=2,x=5 -> outputs return to reset values immediately; after release no frame_start until the pipelined (0,0), and frame_count=0.
